// File: rtl/mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bridge_pkg
//  Description : Shared constants and types for the CPU data-side bus bridge:
//                region decode values, peripheral register indices, the
//                read-data select encoding and the keyboard status packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_bridge_pkg;

    // Address regions
    localparam logic [3:0]  RAM_REGION  = 4'h0;
    localparam logic [31:0] PERIPH_BASE = 32'hF000_0000;

    // Peripheral register indices (mem_addr[3:2])
    localparam logic [1:0] KBD_DATA   = 2'd0;
    localparam logic [1:0] KBD_STATUS = 2'd1;
    localparam logic [1:0] LED        = 2'd2;
    localparam logic [1:0] CYCLE      = 2'd3;

    // Source of the registered load result
    typedef enum logic [1:0] {
        SEL_ZERO   = 2'd0,
        SEL_RAM    = 2'd1,
        SEL_PERIPH = 2'd2
    } rd_sel_t;

    // Keyboard status word: {count[3:0], 0, ovf, full, nonempty}
    function automatic logic [31:0] kbd_status_word(
        input logic [3:0] count,
        input logic       ovf,
        input logic       full,
        input logic       nonempty
    );
        return {24'h0, count, 1'b0, ovf, full, nonempty};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bridge_if
//  Description : Single-cycle CPU data memory port. The CPU drives address,
//                store data and one-cycle load/store strobes; the bridge
//                returns registered load data.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_bridge_if;

    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        wren;
    logic        rden;
    logic [31:0] mem_read_data;

    modport master (
        output mem_addr,
        output mem_write_data,
        output wren,
        output rden,
        input  mem_read_data
    );

    modport slave (
        input  mem_addr,
        input  mem_write_data,
        input  wren,
        input  rden,
        output mem_read_data
    );

endinterface
`default_nettype wire

// File: rtl/mem_bridge_kbd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : kbd_fifo
//  Description : Keyboard scan-code FIFO with sticky overflow flag. A push
//                into a full FIFO is dropped unless a pop happens in the same
//                cycle; a pop of an empty FIFO is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module kbd_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       push,
    input  wire logic [7:0] din,
    input  wire logic       pop,
    input  wire logic       ovf_clr,
    output logic [7:0]      dout,
    output logic [4:0]      count,
    output logic            full,
    output logic            nonempty,
    output logic            ovf
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    logic w_full;
    logic w_nonempty;
    logic w_pop_ok;
    logic w_push_ok;
    logic w_drop;

    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_nonempty = (r_count != '0);
    assign w_pop_ok   = pop & w_nonempty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push_ok  = push & (~w_full | w_pop_ok);
    assign w_drop     = push & w_full & ~w_pop_ok;

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; power-of-2 depth makes the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_drop | (r_ovf & ~ovf_clr);
        end
    end

    assign dout     = r_mem[r_rd_ptr];
    assign count    = 5'(r_count);
    assign full     = w_full;
    assign nonempty = w_nonempty;
    assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: rtl/mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bridge
//  Description : CPU data-side bridge. Decodes the CPU address into the word
//                RAM, the peripheral block (keyboard FIFO data/status, LED
//                register, cycle counter) or unmapped space, and returns a
//                registered load result one cycle after the load strobe.
//                Optional feature macro: MEM_BRIDGE_CYCLE_CNT_EN enables the
//                32-bit cycle counter behind the CYCLE register.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int RAM_AW     = 12
) (
    input  wire logic              clk,
    input  wire logic              rst,
    mem_bridge_if.slave            cpu,
    output logic [RAM_AW-1:0]      ram_addr,
    output logic [31:0]            ram_wdata,
    output logic                   ram_we,
    input  wire logic [31:0]       ram_rdata,
    input  wire logic              kbd_valid,
    input  wire logic [7:0]        kbd_code,
    output logic [15:0]            led,
    output logic                   bus_err
);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       w_ram_sel;
    logic       w_periph_sel;
    logic       w_unmapped;
    logic [1:0] w_reg_idx;
    logic       w_wr;
    logic       w_rd;

    assign w_ram_sel    = (cpu.mem_addr[31:28] == RAM_REGION);
    assign w_periph_sel = (cpu.mem_addr[31:4] == PERIPH_BASE[31:4]);
    assign w_unmapped   = ~w_ram_sel & ~w_periph_sel;
    assign w_reg_idx    = cpu.mem_addr[3:2];

    // Strobes seen during reset are discarded.
    assign w_wr = cpu.wren & ~rst;
    assign w_rd = cpu.rden & ~rst;

    // ------------------------------------------------------------------
    // RAM pass-through
    // ------------------------------------------------------------------
    assign ram_addr  = cpu.mem_addr[RAM_AW+1:2];
    assign ram_wdata = cpu.mem_write_data;
    assign ram_we    = w_wr & w_ram_sel;

    // ------------------------------------------------------------------
    // Keyboard FIFO
    // ------------------------------------------------------------------
    logic       w_kbd_push;
    logic       w_kbd_pop;
    logic       w_ovf_clr;
    logic [7:0] w_kbd_dout;
    logic [4:0] w_kbd_count;
    logic       w_kbd_full;
    logic       w_kbd_nonempty;
    logic       w_kbd_ovf;

    assign w_kbd_push = kbd_valid & ~rst;
    assign w_kbd_pop  = w_rd & w_periph_sel & (w_reg_idx == KBD_DATA);
    assign w_ovf_clr  = w_wr & w_periph_sel & (w_reg_idx == KBD_STATUS)
                        & cpu.mem_write_data[2];

    kbd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_kbd_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_kbd_push),
        .din      (kbd_code),
        .pop      (w_kbd_pop),
        .ovf_clr  (w_ovf_clr),
        .dout     (w_kbd_dout),
        .count    (w_kbd_count),
        .full     (w_kbd_full),
        .nonempty (w_kbd_nonempty),
        .ovf      (w_kbd_ovf)
    );

    // ------------------------------------------------------------------
    // LED register
    // ------------------------------------------------------------------
    logic [15:0] r_led;
    logic        w_led_wr;

    assign w_led_wr = w_wr & w_periph_sel & (w_reg_idx == LED);

    // LED register holds the low half of the last store to it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led <= '0;
        end else if (w_led_wr) begin
            r_led <= cpu.mem_write_data[15:0];
        end
    end

    assign led = r_led;

    // ------------------------------------------------------------------
    // Cycle counter
    // ------------------------------------------------------------------
    logic [31:0] w_cycle_val;

`ifdef MEM_BRIDGE_CYCLE_CNT_EN
    logic [31:0] r_cycle;
    logic        w_cycle_wr;

    assign w_cycle_wr = w_wr & w_periph_sel & (w_reg_idx == CYCLE);

    // Free-running counter; a write restarts it with the write cycle counted as 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle <= '0;
        end else if (w_cycle_wr) begin
            r_cycle <= 32'd1;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    assign w_cycle_val = r_cycle;
`else
    assign w_cycle_val = '0;
`endif

    // ------------------------------------------------------------------
    // Peripheral read data (pre-update values of this cycle)
    // ------------------------------------------------------------------
    logic [31:0] w_periph_rdata;

    // Select the addressed peripheral register for a load.
    always_comb begin
        w_periph_rdata = '0;
        case (w_reg_idx)
            KBD_DATA:   w_periph_rdata = w_kbd_nonempty ? {24'h0, w_kbd_dout} : 32'h0;
            KBD_STATUS: w_periph_rdata = kbd_status_word(w_kbd_count[3:0], w_kbd_ovf,
                                                         w_kbd_full, w_kbd_nonempty);
            LED:        w_periph_rdata = {16'h0, r_led};
            CYCLE:      w_periph_rdata = w_cycle_val;
            default:    w_periph_rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered load path and bus error
    // ------------------------------------------------------------------
    rd_sel_t     r_rd_sel;
    logic [31:0] r_rd_data;
    logic        r_bus_err;

    // Capture the load source on the rden edge; RAM data arrives live next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_sel  <= SEL_ZERO;
            r_rd_data <= '0;
        end else if (w_rd) begin
            if (w_ram_sel) begin
                r_rd_sel <= SEL_RAM;
            end else if (w_periph_sel) begin
                r_rd_sel  <= SEL_PERIPH;
                r_rd_data <= w_periph_rdata;
            end else begin
                r_rd_sel <= SEL_ZERO;
            end
        end
    end

    // One-cycle error pulse after any strobe into unmapped space.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= (cpu.wren | cpu.rden) & w_unmapped;
        end
    end

    logic [31:0] w_rd_mux;

    // Final load-result mux.
    always_comb begin
        w_rd_mux = '0;
        case (r_rd_sel)
            SEL_RAM:    w_rd_mux = ram_rdata;
            SEL_PERIPH: w_rd_mux = r_rd_data;
            default:    w_rd_mux = '0;
        endcase
    end

    assign cpu.mem_read_data = w_rd_mux;
    assign bus_err           = r_bus_err;

    // Byte-offset bits and the count MSB have no function here.
    logic w_unused_bits;
    assign w_unused_bits = ^{cpu.mem_addr[1:0], w_kbd_count[4]};

endmodule
`default_nettype wire

// File: tb/tb_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bridge
//  Description : Self-checking bench for mem_bridge. A queue/array model
//                predicts every visible output each cycle; directed tests add
//                hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bridge;

    localparam int FIFO_DEPTH = 8;
    localparam int RAM_AW     = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_bridge_if cpu ();

    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_we;
    logic [31:0]       ram_rdata;
    logic              kbd_valid;
    logic [7:0]        kbd_code;
    logic [15:0]       led;
    logic              bus_err;

    mem_bridge #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .RAM_AW     (RAM_AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu       (cpu),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .kbd_valid (kbd_valid),
        .kbd_code  (kbd_code),
        .led       (led),
        .bus_err   (bus_err)
    );

    // Synchronous read-first RAM attached to the bridge
    logic [31:0] ram_mem [2**RAM_AW];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [7:0]  m_q [$];
    logic        m_ovf = 1'b0;
    logic [15:0] m_led = '0;
    logic [31:0] m_mem [2**RAM_AW];
    logic        m_is_ram = 1'b0;
    logic        m_ram_fresh = 1'b0;
    logic [31:0] m_rd_val = '0;
    logic        m_bus_err = 1'b0;
    logic        m_started = 1'b0;
`ifdef MEM_BRIDGE_CYCLE_CNT_EN
    logic [31:0] m_cycle = '0;
`endif

    always @(posedge clk) begin
        logic [31:0] a;
        logic        is_ram, is_per, pop, full, drop, clr;
        logic [1:0]  idx;
        m_started = 1'b1;
        if (rst) begin
            m_q.delete();
            m_ovf = 0; m_led = 0; m_is_ram = 0; m_ram_fresh = 0;
            m_rd_val = 0; m_bus_err = 0;
`ifdef MEM_BRIDGE_CYCLE_CNT_EN
            m_cycle = 0;
`endif
        end else begin
            a      = cpu.mem_addr;
            is_ram = (a[31:28] == 4'h0);
            is_per = (a[31:4] == 28'hF000000);
            idx    = a[3:2];
            m_bus_err   = (cpu.wren || cpu.rden) && !is_ram && !is_per;
            m_ram_fresh = 0;
            if (cpu.rden) begin
                if (is_ram) begin
                    m_is_ram = 1; m_ram_fresh = 1;
                    m_rd_val = m_mem[a[RAM_AW+1:2]];
                end else begin
                    m_is_ram = 0;
                    m_rd_val = 0;
                    if (is_per) begin
                        case (idx)
                            2'd0: m_rd_val = (m_q.size() > 0) ? {24'h0, m_q[0]} : 32'h0;
                            2'd1: m_rd_val = {24'h0, 4'(m_q.size()), 1'b0, m_ovf,
                                              m_q.size() == FIFO_DEPTH, m_q.size() != 0};
                            2'd2: m_rd_val = {16'h0, m_led};
`ifdef MEM_BRIDGE_CYCLE_CNT_EN
                            default: m_rd_val = m_cycle;
`else
                            default: m_rd_val = 0;
`endif
                        endcase
                    end
                end
            end
            pop  = cpu.rden && is_per && idx == 2'd0 && m_q.size() > 0;
            full = (m_q.size() == FIFO_DEPTH);
            drop = kbd_valid && full && !pop;
            clr  = cpu.wren && is_per && idx == 2'd1 && cpu.mem_write_data[2];
            if (pop) void'(m_q.pop_front());
            if (kbd_valid && !drop) m_q.push_back(kbd_code);
            m_ovf = drop || (m_ovf && !clr);
            if (cpu.wren && is_per && idx == 2'd2) m_led = cpu.mem_write_data[15:0];
            if (cpu.wren && is_ram) m_mem[a[RAM_AW+1:2]] = cpu.mem_write_data;
`ifdef MEM_BRIDGE_CYCLE_CNT_EN
            if (cpu.wren && is_per && idx == 2'd3) m_cycle = 32'd1;
            else m_cycle = m_cycle + 32'd1;
`endif
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_started) begin
            check("ram_we", {31'h0, ram_we},
                  {31'h0, !rst && cpu.wren && cpu.mem_addr[31:28] == 4'h0});
            check("ram_addr", {20'h0, ram_addr}, {20'h0, cpu.mem_addr[RAM_AW+1:2]});
            check("ram_wdata", ram_wdata, cpu.mem_write_data);
            check("led", {16'h0, led}, {16'h0, m_led});
            check("bus_err", {31'h0, bus_err}, {31'h0, m_bus_err});
            if (!m_is_ram || m_ram_fresh)
                check("mem_read_data", cpu.mem_read_data, m_rd_val);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all start and end just after a rising edge)
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic bus(input logic w, input logic r, input logic [31:0] addr, input logic [31:0] data);
        cpu.wren = w; cpu.rden = r; cpu.mem_addr = addr; cpu.mem_write_data = data;
        step();
        cpu.wren = 0; cpu.rden = 0;
    endtask

    task automatic read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus(0, 1, addr, 32'h0);
        @(negedge clk);
        check(name, cpu.mem_read_data, exp);
        step();
    endtask

    task automatic push(input logic [7:0] code);
        kbd_valid = 1; kbd_code = code;
        step();
        kbd_valid = 0;
    endtask

    localparam logic [31:0] A_KDATA = 32'hF000_0000;
    localparam logic [31:0] A_KSTAT = 32'hF000_0004;
    localparam logic [31:0] A_LED   = 32'hF000_0008;
    localparam logic [31:0] A_CYCLE = 32'hF000_000C;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_codes [8];
        for (int i = 0; i < 2**RAM_AW; i++) begin
            ram_mem[i] = 32'h0;
            m_mem[i]   = 32'h0;
        end
        rst = 1; kbd_valid = 0; kbd_code = 0;
        cpu.wren = 0; cpu.rden = 0; cpu.mem_addr = 0; cpu.mem_write_data = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rdata", cpu.mem_read_data, 32'h0);
        check("reset_led", {16'h0, led}, 32'h0);
        check("reset_bus_err", {31'h0, bus_err}, 32'h0);
        step();
        rst = 0;

        // RAM store / load
        cpu.wren = 1; cpu.mem_addr = 32'h100; cpu.mem_write_data = 32'hDEADBEEF;
        @(negedge clk);
        check("store_ram_we", {31'h0, ram_we}, 32'h1);
        check("store_ram_addr", {20'h0, ram_addr}, 32'h40);
        step();
        cpu.wren = 0;
        read_chk("ram_load", 32'h100, 32'hDEADBEEF);
        bus(1, 0, 32'h0FFF_FFFC, 32'h12345678);
        read_chk("ram_top_word", 32'h0FFF_FFFC, 32'h12345678);
        read_chk("ram_unwritten", 32'h200, 32'h0);

        // FIFO ordering and empty read
        push(8'h1C); push(8'h32); push(8'h21);
        read_chk("kbd_pop1", A_KDATA, 32'h1C);
        read_chk("kbd_pop2", A_KDATA, 32'h32);
        read_chk("kbd_pop3", A_KDATA, 32'h21);
        read_chk("kbd_empty_pop", A_KDATA, 32'h0);
        read_chk("kbd_empty_stat", A_KSTAT, 32'h0);

        // Overflow: 9th push coincides with an ovf clear, so the set wins
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        kbd_valid = 1; kbd_code = 8'h18;
        bus(1, 0, A_KSTAT, 32'h4);
        kbd_valid = 0;
        // count 8 -> 0x80, ovf 0x04, full 0x02, nonempty 0x01
        read_chk("stat_ovf", A_KSTAT, 32'h87);
        bus(1, 0, A_KSTAT, 32'h4);
        read_chk("stat_ovf_clr", A_KSTAT, 32'h83);

        // Full FIFO: push and pop in the same cycle
        kbd_valid = 1; kbd_code = 8'h55;
        bus(0, 1, A_KDATA, 32'h0);
        kbd_valid = 0;
        @(negedge clk);
        check("full_pushpop", cpu.mem_read_data, 32'h10);
        step();
        read_chk("stat_after_pushpop", A_KSTAT, 32'h83);
        for (int i = 0; i < 7; i++) exp_codes[i] = 8'(8'h11 + i);
        exp_codes[7] = 8'h55;
        for (int i = 0; i < 8; i++) read_chk("drain", A_KDATA, {24'h0, exp_codes[i]});

        // Push and pop while empty
        kbd_valid = 1; kbd_code = 8'h77;
        bus(0, 1, A_KDATA, 32'h0);
        kbd_valid = 0;
        @(negedge clk);
        check("empty_pushpop", cpu.mem_read_data, 32'h0);
        step();
        read_chk("stat_one", A_KSTAT, 32'h11);
        read_chk("pop_77", A_KDATA, 32'h77);

        // LED register
        bus(1, 0, A_LED, 32'hFFFF_A5A5);
        @(negedge clk);
        check("led_store", {16'h0, led}, 32'hA5A5);
        step();
        read_chk("led_read", A_LED, 32'h0000_A5A5);
        bus(1, 1, A_LED, 32'h0000_1234);
        @(negedge clk);
        check("led_rw_pre", cpu.mem_read_data, 32'h0000_A5A5);
        check("led_rw_new", {16'h0, led}, 32'h1234);
        step();

        // Unmapped accesses
        bus(1, 0, 32'h2000_0000, 32'hFFFF_FFFF);
        @(negedge clk);
        check("unmapped_bus_err", {31'h0, bus_err}, 32'h1);
        check("unmapped_led", {16'h0, led}, 32'h1234);
        step();
        bus(0, 1, 32'hF000_0010, 32'h0);
        @(negedge clk);
        check("unmapped_rd", cpu.mem_read_data, 32'h0);
        check("unmapped_rd_err", {31'h0, bus_err}, 32'h1);
        step();

        // Reset mid-use: FIFO and LED cleared, strobe during reset ignored
        push(8'h01); push(8'h02);
        rst = 1;
        bus(1, 0, A_LED, 32'hFFFF);
        step();
        rst = 0;
        @(negedge clk);
        check("led_after_rst", {16'h0, led}, 32'h0);
        step();
        read_chk("stat_after_rst", A_KSTAT, 32'h0);

        // Cycle counter: write, then read ten cycles later
        bus(1, 0, A_CYCLE, 32'hDEAD);
        repeat (9) step();
`ifdef MEM_BRIDGE_CYCLE_CNT_EN
        read_chk("cycle_10", A_CYCLE, 32'd10);
`else
        read_chk("cycle_off", A_CYCLE, 32'd0);
`endif

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
